// File: rtl/mem_ctrl_if.sv
// Bus bundle between the memory controller, its two requesters (ICache, LSB)
// and the byte-wide RAM/IO port.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              if_valid;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_instr;

    logic              lsb_valid;
    logic              lsb_wr;
    logic [1:0]        lsb_len;
    logic [ADDR_W-1:0] lsb_addr;
    logic [31:0]       lsb_wdata;
    logic              lsb_done;
    logic [31:0]       lsb_rdata;

    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              io_buffer_full;

    // Requesters plus the RAM/IO side of the system.
    modport master (
        output if_valid, if_addr, lsb_valid, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
               mem_din, io_buffer_full,
        input  if_done, if_instr, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
    );

    // The controller itself.
    modport slave (
        input  if_valid, if_addr, lsb_valid, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
               mem_din, io_buffer_full,
        output if_done, if_instr, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Single-port RAM controller: arbitrates ICache fetches and LSB loads/stores
// onto a byte-wide port, serialising each access into little-endian bytes.
module mem_ctrl #(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h0003_0000)
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    input  logic      jump_wrong,
    mem_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, IFETCH, LOAD, STORE, DONE} state_t;
    typedef enum logic {GRANT_IF, GRANT_LSB} grant_t;

    state_t            state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic              mem_wr_q, mem_wr_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              if_done_q, if_done_d;
    logic              lsb_done_q, lsb_done_d;
    logic [31:0]       if_instr_q, if_instr_d;
    logic [31:0]       lsb_rdata_q, lsb_rdata_d;

    logic       grant_if;
    logic       stall_new;
    logic       stall_cur;
    logic [1:0] ridx;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Round-robin: IF wins a tie only if the LSB had the previous grant.
    assign grant_if  = bus.if_valid && (!bus.lsb_valid || last_grant_q == GRANT_LSB);
    assign stall_new = bus.io_buffer_full && (bus.lsb_addr >= IO_BASE);
    assign stall_cur = bus.io_buffer_full && (addr_q >= IO_BASE);
    // Read byte i is captured two edges after it is issued.
    assign ridx      = 2'(cnt_q - 3'd2);

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; a missed assignment in always_comb infers a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        nbytes_d     = nbytes_q;
        cnt_d        = cnt_q;
        rbuf_d       = rbuf_q;
        mem_a_d      = '0;
        mem_wr_d     = 1'b0;
        mem_dout_d   = 8'h00;
        if_done_d    = 1'b0;
        lsb_done_d   = 1'b0;
        if_instr_d   = if_instr_q;
        lsb_rdata_d  = lsb_rdata_q;

        case (state_q)
            IDLE: begin
                if (!jump_wrong) begin
                    if (grant_if) begin
                        state_d      = IFETCH;
                        last_grant_d = GRANT_IF;
                        addr_d       = bus.if_addr;
                        nbytes_d     = 3'd4;
                        cnt_d        = 3'd1;
                        rbuf_d       = '0;
                        mem_a_d      = bus.if_addr;
                    end else if (bus.lsb_valid) begin
                        last_grant_d = GRANT_LSB;
                        addr_d       = bus.lsb_addr;
                        wdata_d      = bus.lsb_wdata;
                        nbytes_d     = len_bytes(bus.lsb_len);
                        rbuf_d       = '0;
                        if (!bus.lsb_wr) begin
                            state_d = LOAD;
                            cnt_d   = 3'd1;
                            mem_a_d = bus.lsb_addr;
                        end else if (stall_new) begin
                            state_d = STORE;
                            cnt_d   = 3'd0;
                        end else begin
                            state_d    = STORE;
                            cnt_d      = 3'd1;
                            mem_a_d    = bus.lsb_addr;
                            mem_wr_d   = 1'b1;
                            mem_dout_d = bus.lsb_wdata[7:0];
                        end
                    end
                end
            end

            IFETCH, LOAD: begin
                if (jump_wrong) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    if (cnt_q < nbytes_q) mem_a_d = addr_q + ADDR_W'(cnt_q);
                    if (cnt_q >= 3'd2) rbuf_d[{ridx, 3'b000} +: 8] = bus.mem_din;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == nbytes_q + 3'd1) begin
                        state_d = DONE;
                        cnt_d   = 3'd0;
                        if (state_q == IFETCH) begin
                            if_done_d  = 1'b1;
                            if_instr_d = rbuf_d;
                        end else begin
                            lsb_done_d  = 1'b1;
                            lsb_rdata_d = rbuf_d;
                        end
                    end
                end
            end

            // A store always runs to completion; only IO back-pressure delays it.
            STORE: begin
                if (cnt_q == nbytes_q) begin
                    state_d    = DONE;
                    cnt_d      = 3'd0;
                    lsb_done_d = 1'b1;
                end else if (!stall_cur) begin
                    mem_a_d    = addr_q + ADDR_W'(cnt_q);
                    mem_wr_d   = 1'b1;
                    mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    cnt_d      = cnt_q + 3'd1;
                end
            end

            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_IF;
            addr_q       <= '0;
            wdata_q      <= '0;
            nbytes_q     <= '0;
            cnt_q        <= '0;
            rbuf_q       <= '0;
            mem_a_q      <= '0;
            mem_wr_q     <= 1'b0;
            mem_dout_q   <= 8'h00;
            if_done_q    <= 1'b0;
            lsb_done_q   <= 1'b0;
            if_instr_q   <= '0;
            lsb_rdata_q  <= '0;
        end else if (rdy) begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            nbytes_q     <= nbytes_d;
            cnt_q        <= cnt_d;
            rbuf_q       <= rbuf_d;
            mem_a_q      <= mem_a_d;
            mem_wr_q     <= mem_wr_d;
            mem_dout_q   <= mem_dout_d;
            if_done_q    <= if_done_d;
            lsb_done_q   <= lsb_done_d;
            if_instr_q   <= if_instr_d;
            lsb_rdata_q  <= lsb_rdata_d;
        end
    end

    assign bus.mem_a     = mem_a_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_dout  = mem_dout_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_instr  = if_instr_q;
    assign bus.lsb_done  = lsb_done_q;
    assign bus.lsb_rdata = lsb_rdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-RAM model, vector table of loads/stores,
// and hand-written sequences for arbitration, flush, IO stall, rdy and reset.
module tb_mem_ctrl;
    logic clk;
    logic rst;
    logic rdy;
    logic jump_wrong;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32), .IO_BASE(32'h0003_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .jump_wrong (jump_wrong),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct {
        logic        wr;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_viol  = 0;
    logic        in_store = 1'b0;
    logic [7:0]  ram [int];
    wr_t         wq[$];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(int'(a)) ? ram[int'(a)] : 8'h00;
    endfunction

    // Registered-read byte RAM gated by rdy, logging every write.
    always @(posedge clk) begin
        if (rdy) begin
            bus.mem_din <= ram_rd(bus.mem_a);
            if (bus.mem_wr) begin
                ram[int'(bus.mem_a)] = bus.mem_dout;
                wq.push_back('{bus.mem_a, bus.mem_dout});
            end
        end
    end

    always @(negedge clk) if (bus.mem_wr && !in_store) wr_viol++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_lsb(input logic wr, input logic [1:0] len, input logic [31:0] addr,
                          input logic [31:0] wdata, input int jump_at, input int rdy_off_at,
                          output logic [31:0] rdata, output int lat);
        logic [31:0] held_a;
        held_a        = '0;
        lat           = 0;
        bus.lsb_wr    = wr;
        bus.lsb_len   = len;
        bus.lsb_addr  = addr;
        bus.lsb_wdata = wdata;
        bus.lsb_valid = 1'b1;
        in_store      = wr;
        for (int c = 1; c <= 40; c++) begin
            tick();
            jump_wrong = 1'b0;
            if (bus.lsb_done) begin
                lat = c;
                break;
            end
            if (rdy_off_at != 0 && c > rdy_off_at && c <= rdy_off_at + 2)
                check($sformatf("rdy hold mem_a c%0d", c), bus.mem_a, held_a);
            if (c == jump_at) jump_wrong = 1'b1;
            if (c == rdy_off_at) begin
                held_a = bus.mem_a;
                rdy    = 1'b0;
            end
            if (rdy_off_at != 0 && c == rdy_off_at + 2) rdy = 1'b1;
        end
        jump_wrong    = 1'b0;
        rdy           = 1'b1;
        bus.lsb_valid = 1'b0;
        in_store      = 1'b0;
        rdata         = bus.lsb_rdata;
        tick();
    endtask

    task automatic do_fetch(input logic [31:0] addr, input int jump_at, input int budget,
                            output logic [31:0] instr, output int lat);
        lat          = 0;
        bus.if_addr  = addr;
        bus.if_valid = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            tick();
            jump_wrong = 1'b0;
            if (bus.if_done) begin
                lat = c;
                break;
            end
            if (jump_at != 0 && c == jump_at + 1) begin
                check("flush mem_a", bus.mem_a, 32'h0);
                check("flush mem_wr", {31'b0, bus.mem_wr}, 32'h0);
            end
            if (c == jump_at) begin
                jump_wrong   = 1'b1;
                bus.if_valid = 1'b0;
            end
        end
        jump_wrong   = 1'b0;
        bus.if_valid = 1'b0;
        instr        = bus.if_instr;
        tick();
    endtask

    task automatic check_stores(input string name, input logic [1:0] len,
                                input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        check({name, " nwrites"}, wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++) begin
            check($sformatf("%s addr%0d", name, i), wq[i].a, addr + i);
            check($sformatf("%s byte%0d", name, i), {24'b0, wq[i].d}, (wdata >> (8 * i)) & 32'hFF);
        end
    endtask

    vec_t        vecs[9];
    logic [31:0] rd;
    int          lat;
    int          ngrant;
    int          dbl;
    int          order[3];
    int          when[3];
    logic [31:0] gdata[3];
    logic [31:0] exp_a[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 2'b11, 32'h200, 32'hDEADBEEF, 32'h0,        5};
        vecs[1] = '{1'b0, 2'b11, 32'h200, 32'h0,        32'hDEADBEEF, 6};
        vecs[2] = '{1'b0, 2'b00, 32'h201, 32'h0,        32'h000000BE, 3};
        vecs[3] = '{1'b0, 2'b01, 32'h202, 32'h0,        32'h0000DEAD, 4};
        vecs[4] = '{1'b1, 2'b01, 32'h300, 32'h12345678, 32'h0,        3};
        vecs[5] = '{1'b1, 2'b00, 32'h302, 32'hAABBCC99, 32'h0,        2};
        vecs[6] = '{1'b0, 2'b10, 32'h300, 32'h0,        32'h00995678, 6};
        vecs[7] = '{1'b0, 2'b01, 32'h100, 32'h0,        32'h00000513, 4};
        vecs[8] = '{1'b0, 2'b00, 32'h102, 32'h0,        32'h00000010, 3};

        ram[32'h100] = 8'h13;
        ram[32'h101] = 8'h05;
        ram[32'h102] = 8'h10;
        ram[32'h103] = 8'h00;

        rst = 1'b1; rdy = 1'b1; jump_wrong = 1'b0;
        bus.if_valid = 1'b0; bus.if_addr = '0;
        bus.lsb_valid = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_len = 2'b00;
        bus.lsb_addr = '0; bus.lsb_wdata = '0; bus.io_buffer_full = 1'b0;
        tick(); tick();
        check("reset mem_a", bus.mem_a, 32'h0);
        check("reset outputs", {bus.mem_wr, bus.if_done, bus.lsb_done, bus.mem_dout}, 32'h0);
        check("reset if_instr", bus.if_instr, 32'h0);
        check("reset lsb_rdata", bus.lsb_rdata, 32'h0);
        rst = 1'b0;
        tick();

        // Arbitration: both held valid; expect LSB, IF, LSB with a gap cycle.
        bus.if_addr = 32'h100;
        bus.lsb_wr = 1'b0; bus.lsb_len = 2'b11; bus.lsb_addr = 32'h100;
        bus.if_valid = 1'b1; bus.lsb_valid = 1'b1;
        ngrant = 0; dbl = 0;
        for (int c = 1; c <= 40 && ngrant < 3; c++) begin
            tick();
            if (bus.if_done && bus.lsb_done) dbl++;
            if (bus.if_done || bus.lsb_done) begin
                order[ngrant] = bus.lsb_done ? 1 : 0;
                when[ngrant]  = c;
                gdata[ngrant] = bus.lsb_done ? bus.lsb_rdata : bus.if_instr;
                ngrant++;
                if (ngrant == 3) begin
                    bus.if_valid = 1'b0;
                    bus.lsb_valid = 1'b0;
                end
            end
        end
        bus.if_valid = 1'b0; bus.lsb_valid = 1'b0;
        check("arb grants", ngrant, 3);
        check("arb both done", dbl, 0);
        for (int g = 0; g < 3 && g < ngrant; g++) begin
            check($sformatf("arb order%0d", g), order[g], (g == 1) ? 0 : 1);
            check($sformatf("arb cycle%0d", g), when[g], 6 + 7 * g);
            check($sformatf("arb data%0d", g), gdata[g], 32'h00100513);
        end
        tick();

        // Fetch with cycle-by-cycle address trace.
        exp_a[0] = 32'h100; exp_a[1] = 32'h101; exp_a[2] = 32'h102;
        exp_a[3] = 32'h103; exp_a[4] = 32'h0;
        bus.if_addr = 32'h100; bus.if_valid = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c <= 5) begin
                check($sformatf("fetch mem_a c%0d", c), bus.mem_a, exp_a[c-1]);
                check($sformatf("fetch ctl c%0d", c), {bus.mem_wr, bus.if_done}, 32'h0);
            end else if (c == 6) begin
                check("fetch if_done", {31'b0, bus.if_done}, 32'h1);
                check("fetch if_instr", bus.if_instr, 32'h00100513);
                bus.if_valid = 1'b0;
            end else begin
                check("fetch pulse width", {31'b0, bus.if_done}, 32'h0);
            end
        end

        for (int i = 0; i < 9; i++) begin
            wq.delete();
            do_lsb(vecs[i].wr, vecs[i].len, vecs[i].addr, vecs[i].wdata, 0, 0, rd, lat);
            check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
            if (vecs[i].wr)
                check_stores($sformatf("vec%0d", i), vecs[i].len, vecs[i].addr, vecs[i].wdata);
            else
                check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
        end

        // Flush mid-fetch: no done, then a normal access still works.
        do_fetch(32'h100, 3, 12, rd, lat);
        check("flush fetch no done", lat, 0);
        do_lsb(1'b0, 2'b00, 32'h201, 32'h0, 0, 0, rd, lat);
        check("after flush latency", lat, 3);
        check("after flush rdata", rd, 32'h000000BE);

        // Flush mid-store is ignored.
        wq.delete();
        do_lsb(1'b1, 2'b11, 32'h400, 32'hCAFEF00D, 2, 0, rd, lat);
        check("flush store latency", lat, 5);
        check_stores("flush store", 2'b11, 32'h400, 32'hCAFEF00D);

        // IO back-pressure on a single-byte store.
        wq.delete();
        bus.lsb_wr = 1'b1; bus.lsb_len = 2'b00; bus.lsb_addr = 32'h0003_0000;
        bus.lsb_wdata = 32'h0000005A; bus.lsb_valid = 1'b1; in_store = 1'b1;
        bus.io_buffer_full = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c <= 3) check($sformatf("io stall mem_wr c%0d", c), {31'b0, bus.mem_wr}, 32'h0);
            if (c == 3) bus.io_buffer_full = 1'b0;
            if (c == 4) begin
                check("io write mem_wr", {31'b0, bus.mem_wr}, 32'h1);
                check("io write mem_a", bus.mem_a, 32'h0003_0000);
                check("io write byte", {24'b0, bus.mem_dout}, 32'h5A);
            end
            if (c == 5) begin
                check("io lsb_done", {31'b0, bus.lsb_done}, 32'h1);
                bus.lsb_valid = 1'b0; in_store = 1'b0;
            end
        end
        tick();
        check("io nwrites", wq.size(), 1);

        // Loads ignore io_buffer_full.
        bus.io_buffer_full = 1'b1;
        do_lsb(1'b0, 2'b00, 32'h0003_0000, 32'h0, 0, 0, rd, lat);
        bus.io_buffer_full = 1'b0;
        check("io load latency", lat, 3);
        check("io load rdata", rd, 32'h0000005A);

        // rdy low for two cycles mid-load.
        do_lsb(1'b0, 2'b11, 32'h200, 32'h0, 0, 3, rd, lat);
        check("rdy load latency", lat, 8);
        check("rdy load rdata", rd, 32'hDEADBEEF);

        // Reset in the middle of a store.
        bus.lsb_wr = 1'b1; bus.lsb_len = 2'b11; bus.lsb_addr = 32'h500;
        bus.lsb_wdata = 32'h11223344; bus.lsb_valid = 1'b1; in_store = 1'b1;
        tick(); tick();
        check("pre-reset store active", {31'b0, bus.mem_wr}, 32'h1);
        rst = 1'b1; bus.lsb_valid = 1'b0;
        #1;
        in_store = 1'b0;
        check("midreset mem_a", bus.mem_a, 32'h0);
        check("midreset ctl", {bus.mem_wr, bus.if_done, bus.lsb_done, bus.mem_dout}, 32'h0);
        check("midreset data", bus.if_instr | bus.lsb_rdata, 32'h0);
        tick(); tick();
        check("reset held done", {bus.if_done, bus.lsb_done}, 32'h0);
        rst = 1'b0;
        tick();
        do_fetch(32'h100, 0, 20, rd, lat);
        check("post-reset fetch latency", lat, 6);
        check("post-reset fetch instr", rd, 32'h00100513);

        check("mem_wr outside store", wr_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port RAM controller and arbiter.
- Shares the byte-wide RAM/IO port between the instruction cache (word fetch) and the load/store buffer (1/2/4-byte loads and stores).
- Serialises each request into little-endian byte transfers, assembles read data, and returns a one-cycle done pulse to the requester.
- Handles misprediction flush and the IO write back-pressure flag.

Parameters:
- ADDR_W, 32, width of all address ports
- IO_BASE, 32'h0003_0000, addresses >= IO_BASE are IO-mapped (subject to io_buffer_full)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global enable; when low, all registers hold
- jump_wrong  in  1  misprediction flush
- if_valid  in  1  ICache fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address
- if_done  out  1  one-cycle pulse, if_instr valid
- if_instr  out  32  fetched word
- lsb_valid  in  1  LSB request, held until lsb_done
- lsb_wr  in  1  1=store, 0=load
- lsb_len  in  2  00=1 byte, 01=2 bytes, 11=4 bytes (10 treated as 4)
- lsb_addr  in  ADDR_W  access address
- lsb_wdata  in  32  store data, low bytes used
- lsb_done  out  1  one-cycle pulse, load/store complete
- lsb_rdata  out  32  load data, zero-extended
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_W  RAM byte address
- mem_wr  out  1  1=write, 0=read
- io_buffer_full  in  1  IO write buffer full

Behaviour:
- Reset: state=IDLE, mem_a=0, mem_wr=0, mem_dout=0, if_done=0, lsb_done=0, if_instr=0, lsb_rdata=0, byte counters=0, last_grant=IF.
- rdy low: every register holds. The RAM is gated by the same rdy at top level.

States:
- IDLE: may accept a request.
- IFETCH, LOAD, STORE: transfer in progress.
- DONE: the done pulse is high for this single cycle; no request is accepted; next state is IDLE. This gap lets requesters drop valid.

Arbitration (IDLE only):
- Only one valid: grant it.
- Both valid: grant the requester opposite to last_grant (round-robin); update last_grant.
- Requester inputs (address, len, wdata) are latched at the accept edge and ignored afterwards.

Byte i of an access is at address A+i and maps to data[8i+7:8i].

Read timing (n bytes, accept edge E0):
- mem_a=A+i, mem_wr=0 is driven after edge E0+i.
- The byte arrives on mem_din after E0+i+1 and is captured at edge E0+i+2.
- The done pulse and data are visible in the cycle after edge E0+n+1. For a fetch this is 5 cycles after accept.

Write timing (n bytes):
- mem_a=A+i, mem_wr=1, mem_dout=byte i is driven after edge E0+i.
- The done pulse is visible after edge E0+n.

Between transfers:
- In IDLE and DONE, mem_wr=0 and mem_a=0.
- mem_wr is never high outside STORE.

IO back-pressure:
- Applies in STORE when A >= IO_BASE and io_buffer_full is sampled high.
- The pending byte is not issued that cycle: mem_wr=0, mem_a=0, counter holds.
- Issue resumes the first cycle io_buffer_full is low.
- Loads ignore io_buffer_full.

jump_wrong (sampled at an edge, rdy high):
- In IFETCH or LOAD: abort. Next state is IDLE, no done pulse, mem_wr=0, captured bytes discarded.
- In STORE: ignored; the store completes and signals lsb_done.
- In IDLE: no request is accepted at that edge.
- In DONE: the pulse still occurs.
- Requesters drop valid on jump_wrong; the controller relies on that.

Data outputs:
- lsb_rdata upper bytes are 0 for 1- and 2-byte loads.
- if_instr and lsb_rdata hold their last value after done until the next completion.

Reset mid-transfer: returns immediately to reset values; no partial done.

Test Plan:
- IFETCH: RAM[0x100..0x103]=13,05,10,00; if_valid, addr 0x100 -> mem_a steps 100,101,102,103 with mem_wr=0; if_done single pulse 5 cycles after accept; if_instr=32'h00100513.
- Store then load: store len=11, addr 0x200, wdata 0xDEADBEEF -> mem_dout EF,BE,AD,DE on 0x200-0x203, lsb_done after 4 cycles. Load len=00 from 0x201 -> lsb_rdata=32'h000000BE.
- Simultaneous if_valid and lsb_valid at reset -> LSB served first (last_grant=IF). Both re-requested -> IF served next. Exactly one done per grant; DONE gap cycle present.
- jump_wrong during fetch byte 2 -> no if_done, mem_wr stays 0, next state IDLE. Repeat during 4-byte store -> all 4 bytes written and lsb_done pulses.
- Store len=00 to 0x30000, io_buffer_full high for 3 cycles -> mem_wr stays 0 for those 3 cycles, then one write of byte 0; lsb_done follows.
- rdy low for 2 cycles mid-load -> mem_a, counter and state frozen; result identical to the uninterrupted run, delayed by 2 cycles. rst asserted mid-store -> all outputs return to 0 immediately.
